// File: rtl/unified_xor_pkg.sv
// Shared types and constants for the unified AES-key-XOR / Keccak-theta engine.
package unified_xor_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    THETA = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Legal range for the number of Keccak beats in one frame.
  localparam int ROWS_MIN = 2;
  localparam int ROWS_MAX = 8;

  // Beat counter width; wide enough to hold ROWS_MAX-1.
  localparam int CNT_W = $clog2(ROWS_MAX);

endpackage

// File: rtl/theta_d_gen.sv
// Keccak theta D-lane generator: D[x] = C[x-1] ^ rotl1(C[x+1]), indices mod N_LANES.
// Purely combinational.
module theta_d_gen #(
  parameter int LANE_W  = 32,
  parameter int N_LANES = 5
) (
  input  logic [N_LANES*LANE_W-1:0] c,
  output logic [N_LANES*LANE_W-1:0] d
);

  // Rotate one lane left by a single bit; the MSB wraps into bit 0.
  function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

  for (genvar x = 0; x < N_LANES; x++) begin : g_lane
    localparam int XM = (x + N_LANES - 1) % N_LANES;
    localparam int XP = (x + 1) % N_LANES;

    logic [LANE_W-1:0] c_prev_s;
    logic [LANE_W-1:0] c_next_s;

    assign c_prev_s = c[XM*LANE_W +: LANE_W];
    assign c_next_s = c[XP*LANE_W +: LANE_W];
    assign d[x*LANE_W +: LANE_W] = c_prev_s ^ rotl1(c_next_s);
  end

endmodule

// File: rtl/unified_xor_engine.sv
// Unified XOR engine: single-beat AES round-key XOR, or multi-beat Keccak
// column-parity accumulation followed by a theta D-lane output beat.
// The mode is latched only at the start of a frame; a Keccak frame holds the
// input off while theta is computed and while its result waits downstream.
module unified_xor_engine
  import unified_xor_pkg::*;
#(
  parameter int LANE_W  = 32,
  parameter int N_LANES = 5,
  parameter int ROWS    = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_aes_or_keccak,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [N_LANES*LANE_W-1:0] i_row,
  input  logic [N_LANES*LANE_W-1:0] i_key,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [N_LANES*LANE_W-1:0] o_data,
  output logic [N_LANES*LANE_W-1:0] o_C,
  output logic                      o_is_theta
);

  localparam int ROW_W = N_LANES * LANE_W;

  state_e             state_r;
  state_e             state_s;
  logic [ROW_W-1:0]   c_r;
  logic [ROW_W-1:0]   c_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               valid_s;
  logic [ROW_W-1:0]   data_s;
  logic [ROW_W-1:0]   c_out_s;
  logic               theta_s;
  logic [ROW_W-1:0]   d_s;
  logic               accept_s;

  theta_d_gen #(
    .LANE_W  (LANE_W),
    .N_LANES (N_LANES)
  ) u_theta_d_gen (
    .c (c_r),
    .d (d_s)
  );

  assign accept_s = i_valid && o_ready;

  // Input handshake: AES streams through, Keccak blocks while output is pending or theta runs.
  always_comb begin
    o_ready = 1'b0;
    if (i_rst) begin
      o_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_aes_or_keccak) begin
            o_ready = !o_valid || i_ready;
          end else begin
            o_ready = !o_valid;
          end
        end
        ACC:     o_ready = 1'b1;
        THETA:   o_ready = 1'b0;
        OUT:     o_ready = 1'b0;
        default: o_ready = 1'b0;
      endcase
    end
  end

  // Next-state and next-datapath values for the FSM and output registers.
  always_comb begin
    state_s = state_r;
    c_s     = c_r;
    cnt_s   = cnt_r;
    valid_s = o_valid;
    data_s  = o_data;
    c_out_s = o_C;
    theta_s = o_is_theta;
    case (state_r)
      IDLE: begin
        if (o_valid && i_ready) begin
          valid_s = 1'b0;
        end else begin
          valid_s = o_valid;
        end
        if (accept_s) begin
          if (i_aes_or_keccak) begin
            data_s  = i_row ^ i_key;
            c_out_s = {ROW_W{1'b0}};
            theta_s = 1'b0;
            valid_s = 1'b1;
          end else begin
            c_s     = i_row;
            cnt_s   = CNT_W'(1);
            state_s = ACC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        // The mode input is deliberately not looked at until the frame ends.
        if (accept_s) begin
          c_s = c_r ^ i_row;
          if (cnt_r == CNT_W'(ROWS - 1)) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = THETA;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      THETA: begin
        data_s  = d_s;
        c_out_s = c_r;
        theta_s = 1'b1;
        valid_s = 1'b1;
        state_s = OUT;
      end
      OUT: begin
        if (i_ready) begin
          valid_s = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= IDLE;
      c_r        <= {ROW_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      o_valid    <= 1'b0;
      o_data     <= {ROW_W{1'b0}};
      o_C        <= {ROW_W{1'b0}};
      o_is_theta <= 1'b0;
    end else begin
      state_r    <= state_s;
      c_r        <= c_s;
      cnt_r      <= cnt_s;
      o_valid    <= valid_s;
      o_data     <= data_s;
      o_C        <= c_out_s;
      o_is_theta <= theta_s;
    end
  end

endmodule

// File: tb/tb_unified_xor_engine.sv
// Directed self-checking bench for unified_xor_engine (default parameters).
module tb_unified_xor_engine;

  localparam int LANE_W  = 32;
  localparam int N_LANES = 5;
  localparam int ROW_W   = LANE_W * N_LANES;

  typedef logic [ROW_W-1:0] row_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_aes_or_keccak;
  logic       i_valid;
  logic       o_ready;
  row_t       i_row;
  row_t       i_key;
  logic       o_valid;
  logic       i_ready;
  row_t       o_data;
  row_t       o_C;
  logic       o_is_theta;

  int errors = 0;
  int checks = 0;

  unified_xor_engine #(
    .LANE_W  (LANE_W),
    .N_LANES (N_LANES),
    .ROWS    (5)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_aes_or_keccak (i_aes_or_keccak),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_row           (i_row),
    .i_key           (i_key),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_data          (o_data),
    .o_C             (o_C),
    .o_is_theta      (o_is_theta)
  );

  always #5 i_clk = ~i_clk;

  function automatic row_t lane(input int idx, input logic [31:0] v);
    row_t r;
    r = '0;
    r[idx*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send(input row_t row, input row_t key);
    int   n;
    logic acc;
    i_valid = 1'b1;
    i_row   = row;
    i_key   = key;
    n       = 0;
    acc     = 1'b0;
    while (!acc && n < 20) begin
      #1;
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles, required accept", n);
    end
  endtask

  task automatic drive_frame(input row_t rows [5]);
    for (int k = 0; k < 5; k++) send(rows[k], {5{32'hFFFF_FFFF}});
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_aes_or_keccak = 1'b1; i_ready = 1'b1;
    i_row = {5{32'hFFFF_FFFF}}; i_key = '0;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", o_ready); end
    step(); step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", o_data); end
    checks++; if (o_C !== '0) begin errors++; $display("FAIL rst_c: got %h expected 0", o_C); end
    checks++; if (o_is_theta !== 1'b0) begin errors++; $display("FAIL rst_theta: got %b expected 0", o_is_theta); end
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", o_ready); end
    step();
  endtask

  task automatic test_keccak_zero();
    row_t rows [5];
    for (int k = 0; k < 5; k++) rows[k] = '0;
    i_aes_or_keccak = 1'b0; i_ready = 1'b0;
    drive_frame(rows);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL kz_early_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL kz_theta_ready: got %b expected 0", o_ready); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL kz_valid: got %b expected 1", o_valid); end
    checks++; if (o_is_theta !== 1'b1) begin errors++; $display("FAIL kz_theta: got %b expected 1", o_is_theta); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL kz_data: got %h expected 0", o_data); end
    checks++; if (o_C !== '0) begin errors++; $display("FAIL kz_c: got %h expected 0", o_C); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL kz_hold_valid: got %b expected 1", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL kz_out_ready: got %b expected 0", o_ready); end
    i_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL kz_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_keccak_lane0();
    row_t rows [5];
    row_t exp_d;
    for (int k = 0; k < 5; k++) rows[k] = '0;
    rows[0] = lane(0, 32'h0000_0001);
    exp_d = lane(1, 32'h0000_0001) | lane(4, 32'h0000_0002);
    i_aes_or_keccak = 1'b0; i_ready = 1'b0;
    drive_frame(rows);
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL k0_valid: got %b expected 1", o_valid); end
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL k0_data: got %h expected %h", o_data, exp_d); end
    checks++; if (o_C !== lane(0, 32'h0000_0001)) begin errors++; $display("FAIL k0_c: got %h expected %h", o_C, lane(0, 32'h0000_0001)); end
    i_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL k0_drain: got %b expected 0", o_valid); end
  endtask

  task automatic test_aes_blocks_keccak();
    i_aes_or_keccak = 1'b1; i_ready = 1'b0;
    send(lane(0, 32'h0000_0005), '0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ab_valid: got %b expected 1", o_valid); end
    checks++; if (o_data !== lane(0, 32'h0000_0005)) begin errors++; $display("FAIL ab_data: got %h expected %h", o_data, lane(0, 32'h0000_0005)); end
    checks++; if (o_C !== '0) begin errors++; $display("FAIL ab_c: got %h expected 0", o_C); end
    checks++; if (o_is_theta !== 1'b0) begin errors++; $display("FAIL ab_theta: got %b expected 0", o_is_theta); end
    i_aes_or_keccak = 1'b0; i_valid = 1'b1; i_row = '0;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ab_block_stall: got %b expected 0", o_ready); end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ab_block_drain: got %b expected 0", o_ready); end
    i_valid = 1'b0;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ab_drained: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ab_ready_after: got %b expected 1", o_ready); end
  endtask

  task automatic test_keccak_lane2();
    row_t rows [5];
    row_t exp_d;
    for (int k = 0; k < 5; k++) rows[k] = '0;
    rows[3] = lane(2, 32'h8000_0000);
    exp_d = lane(1, 32'h0000_0001) | lane(3, 32'h8000_0000);
    i_aes_or_keccak = 1'b0; i_ready = 1'b0;
    drive_frame(rows);
    step();
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL k2_data: got %h expected %h", o_data, exp_d); end
    checks++; if (o_C !== lane(2, 32'h8000_0000)) begin errors++; $display("FAIL k2_c: got %h expected %h", o_C, lane(2, 32'h8000_0000)); end
    checks++; if (o_is_theta !== 1'b1) begin errors++; $display("FAIL k2_theta: got %b expected 1", o_is_theta); end
    i_ready = 1'b1;
    step();
  endtask

  task automatic test_aes_back_to_back();
    row_t exp_q [4];
    row_t held;
    row_t key;
    logic hold_chk;
    int   in_idx;
    int   out_idx;
    key = {5{32'h0F0F_0F0F}};
    for (int k = 0; k < 4; k++) exp_q[k] = {5{32'hF0F0_F0F0}} ^ row_t'(k);
    hold_chk = 1'b0; held = '0; in_idx = 0; out_idx = 0;
    i_aes_or_keccak = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      i_ready = !(cyc == 2 || cyc == 3);
      i_valid = (in_idx < 4);
      i_row   = {5{32'hFFFF_FFFF}} ^ row_t'(in_idx);
      i_key   = key;
      #1;
      if (hold_chk) begin
        checks++;
        if (o_data !== held) begin errors++; $display("FAIL aes_hold: got %h expected %h", o_data, held); end
      end
      hold_chk = o_valid && !i_ready;
      held     = o_data;
      if (o_valid && i_ready) begin
        checks++;
        if (out_idx >= 4) begin
          errors++; $display("FAIL aes_extra: got output %0d expected at most 4", out_idx + 1);
        end else if (o_data !== exp_q[out_idx]) begin
          errors++; $display("FAIL aes_data%0d: got %h expected %h", out_idx, o_data, exp_q[out_idx]);
        end
        out_idx++;
      end
      if (i_valid && o_ready) in_idx++;
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    checks++; if (out_idx !== 4) begin errors++; $display("FAIL aes_count: got %0d expected 4", out_idx); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL aes_final_valid: got %b expected 0", o_valid); end
  endtask

  task automatic test_mode_toggle();
    row_t exp_d;
    row_t exp_c;
    exp_d = lane(0, 32'hC000_0006) | lane(2, 32'h0000_0003) | lane(3, 32'h8000_0001);
    exp_c = lane(1, 32'h0000_0003) | lane(4, 32'hC000_0000);
    i_aes_or_keccak = 1'b0; i_ready = 1'b0;
    send(lane(1, 32'h0000_0003), '0);
    step(); step();
    send('0, '0);
    i_aes_or_keccak = 1'b1;
    send(lane(4, 32'hC000_0000), {5{32'hFFFF_FFFF}});
    i_aes_or_keccak = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mt_no_aes: got %b expected 0", o_valid); end
    step();
    send('0, '0);
    send('0, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mt_early: got %b expected 0", o_valid); end
    step();
    checks++; if (o_is_theta !== 1'b1) begin errors++; $display("FAIL mt_theta: got %b expected 1", o_is_theta); end
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL mt_data: got %h expected %h", o_data, exp_d); end
    checks++; if (o_C !== exp_c) begin errors++; $display("FAIL mt_c: got %h expected %h", o_C, exp_c); end
    i_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    row_t rows [5];
    row_t exp_d;
    i_aes_or_keccak = 1'b0; i_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(lane(0, 32'hFFFF_FFFF), '0);
    i_rst = 1'b1; i_valid = 1'b1; i_row = lane(2, 32'h1234_5678);
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b expected 0", o_ready); end
    step();
    i_rst = 1'b0; i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", o_valid); end
    for (int k = 0; k < 5; k++) rows[k] = '0;
    rows[0] = lane(0, 32'h0000_0001);
    exp_d = lane(1, 32'h0000_0001) | lane(4, 32'h0000_0002);
    drive_frame(rows);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_early: got %b expected 0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rm_out_valid: got %b expected 1", o_valid); end
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL rm_data: got %h expected %h", o_data, exp_d); end
    checks++; if (o_C !== lane(0, 32'h0000_0001)) begin errors++; $display("FAIL rm_c: got %h expected %h", o_C, lane(0, 32'h0000_0001)); end
    i_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_drain: got %b expected 0", o_valid); end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_aes_or_keccak = 1'b0; i_ready = 1'b1;
    i_row = '0; i_key = '0;
    step();
    test_reset();
    test_keccak_zero();
    test_keccak_lane0();
    test_aes_blocks_keccak();
    test_keccak_lane2();
    test_aes_back_to_back();
    test_mode_toggle();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
